// File: rtl/aes_key_schedule.sv
// AES key expansion (FIPS-197) for 128/192/256-bit keys, one schedule word per clock.
// All 4*(NR+1) words are kept and any round key is served through a combinational read port.
// Optional feature: define AES_INV_KEYS_EN to build equivalent-inverse-cipher round keys.
module aes_key_schedule #(
   parameter int unsigned KEY_BITS = 128
) (
   input  logic                HCLK,
   input  logic                rst,
   input  logic                key_valid,
   output logic                key_ready,
   input  logic [KEY_BITS-1:0] keyword,
   output logic                busy,
   output logic                done,
   input  logic [3:0]          rk_idx,
   output logic [127:0]        rk_out,
   output logic                rk_hit,
   output logic [127:0]        rk_inv_out
);

   localparam int unsigned NK = KEY_BITS / 32;
   localparam int unsigned NR = NK + 6;
   localparam int unsigned NW = 4 * (NR + 1);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $fatal(1, "aes_key_schedule: KEY_BITS must be 128, 192 or 256");
   end

   typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [2:0]  phase_q, phase_d;   // tracks i % NK without a divider
   logic [7:0]  rcon_q, rcon_d;
   logic        done_q, done_d;
   logic [31:0] w_q [NW];

   logic        transfer, load, wr_en;
   logic [5:0]  prev_idx, old_idx;
   logic [31:0] prev_w, t_w, new_w;

   assign busy      = (state_q == StExpand);
   assign key_ready = !busy;
   assign done      = done_q;
   assign transfer  = key_valid && key_ready;

   // Recurrence for the next schedule word w[cnt]
   always_comb begin
      prev_idx = (cnt_q != 6'd0) ? cnt_q - 6'd1 : 6'd0;
      old_idx  = (cnt_q >= 6'(NK)) ? cnt_q - 6'(NK) : 6'd0;
      prev_w   = w_q[prev_idx];
      if (phase_q == 3'd0) begin
         t_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
      end else if (NK == 8 && phase_q == 3'd4) begin
         t_w = sub_word(prev_w);
      end else begin
         t_w = prev_w;
      end
      new_w = w_q[old_idx] ^ t_w;
   end

   // Next-state and write-enable decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      rcon_d  = rcon_q;
      done_d  = 1'b0;
      load    = 1'b0;
      wr_en   = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (transfer) begin
               load    = 1'b1;
               cnt_d   = 6'(NK);
               phase_d = 3'd0;
               rcon_d  = 8'h01;
               state_d = StExpand;
            end
         end
         StExpand: begin
            wr_en   = 1'b1;
            cnt_d   = cnt_q + 6'd1;
            phase_d = (phase_q == 3'(NK - 1)) ? 3'd0 : phase_q + 3'd1;
            if (phase_q == 3'd0) rcon_d = xtime(rcon_q);
            if (cnt_q == 6'(NW - 1)) begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control state with synchronous reset
   always_ff @(posedge HCLK) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 6'd0;
         phase_q <= 3'd0;
         rcon_q  <= 8'h01;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
      end
   end

   // Word storage; validity is carried by cnt_q, so no reset is needed here
   always_ff @(posedge HCLK) begin
      if (!rst) begin
         if (load) begin
            for (int i = 0; i < int'(NK); i++) begin
               w_q[i] <= keyword[KEY_BITS-32*(i+1) +: 32];
            end
         end else if (wr_en) begin
            w_q[cnt_q] <= new_w;
         end
      end
   end

   logic [5:0] base;

   // Indexed round-key read, zero unless all four words are present
   always_comb begin
      rk_hit = (rk_idx <= 4'(NR)) && ({1'b0, cnt_q} >= ({1'b0, rk_idx, 2'b00} + 7'd4));
      base   = rk_hit ? {rk_idx, 2'b00} : 6'd0;
      rk_out = rk_hit ? {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]}
                      : 128'h0;
   end

`ifdef AES_INV_KEYS_EN
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   // First and last round keys pass through; middle rounds get InvMixColumns
   always_comb begin
      if (!rk_hit) begin
         rk_inv_out = 128'h0;
      end else if (rk_idx == 4'd0 || rk_idx == 4'(NR)) begin
         rk_inv_out = rk_out;
      end else begin
         rk_inv_out = {inv_mix_col(rk_out[127:96]), inv_mix_col(rk_out[95:64]),
                       inv_mix_col(rk_out[63:32]), inv_mix_col(rk_out[31:0])};
      end
   end
`else
   assign rk_inv_out = 128'h0;
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench: three schedule instances (128/192/256), a table-driven software
// key-expansion model feeding a queue of expected round keys, drained after each done.
module tb_aes_key_schedule;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         kv   [3];
   logic [3:0]   idx  [3];
   logic         kr   [3];
   logic         bz   [3];
   logic         dn   [3];
   logic         hit  [3];
   logic [127:0] rko  [3];
   logic [127:0] rki  [3];
   logic [127:0] kw128;
   logic [191:0] kw192;
   logic [255:0] kw256;

   aes_key_schedule #(.KEY_BITS(128)) u_ks128 (
      .HCLK(clk), .rst(rst), .key_valid(kv[0]), .key_ready(kr[0]), .keyword(kw128),
      .busy(bz[0]), .done(dn[0]), .rk_idx(idx[0]), .rk_out(rko[0]), .rk_hit(hit[0]),
      .rk_inv_out(rki[0])
   );
   aes_key_schedule #(.KEY_BITS(192)) u_ks192 (
      .HCLK(clk), .rst(rst), .key_valid(kv[1]), .key_ready(kr[1]), .keyword(kw192),
      .busy(bz[1]), .done(dn[1]), .rk_idx(idx[1]), .rk_out(rko[1]), .rk_hit(hit[1]),
      .rk_inv_out(rki[1])
   );
   aes_key_schedule #(.KEY_BITS(256)) u_ks256 (
      .HCLK(clk), .rst(rst), .key_valid(kv[2]), .key_ready(kr[2]), .keyword(kw256),
      .busy(bz[2]), .done(dn[2]), .rk_idx(idx[2]), .rk_out(rko[2]), .rk_hit(hit[2]),
      .rk_inv_out(rki[2])
   );

   int checks = 0;
   int errors = 0;
   logic [127:0] exp_q [$];
   logic [31:0]  w_m [60];

   logic [7:0] sbox_t [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   function automatic logic [31:0] sub_w(input logic [31:0] x);
      return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
   endfunction

`ifdef AES_INV_KEYS_EN
   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] m [4];
      logic [7:0] co [4];
      logic [7:0] r [4];
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      co[0] = c[31:24]; co[1] = c[23:16]; co[2] = c[15:8]; co[3] = c[7:0];
      for (int row = 0; row < 4; row++) begin
         r[row] = 8'h00;
         for (int j = 0; j < 4; j++) r[row] = r[row] ^ mul(co[j], m[(j - row + 4) % 4]);
      end
      return {r[0], r[1], r[2], r[3]};
   endfunction
`endif

   // Software expansion; key is right-aligned, first key byte most significant.
   task automatic model_expand(input logic [255:0] key, input int nk);
      logic [31:0] t;
      logic [7:0]  rc;
      int          nw;
      nw = 4 * (nk + 7);
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w_m[i] = key[32*(nk-1-i) +: 32];
      for (int i = nk; i < nw; i++) begin
         t = w_m[i-1];
         if (i % nk == 0) begin
            t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
         end else if (nk == 8 && i % nk == 4) begin
            t = sub_w(t);
         end
         w_m[i] = w_m[i-nk] ^ t;
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic load_key(input int k, input logic [255:0] key, input bit push);
      int nr;
      nr = 4 + 2 * k + 6;
      case (k)
         0:       kw128 = key[127:0];
         1:       kw192 = key[191:0];
         default: kw256 = key;
      endcase
      kv[k] = 1'b1;
      if (push) begin
         model_expand(key, 4 + 2 * k);
         for (int r = 0; r <= nr; r++) exp_q.push_back({w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]});
      end
      @(negedge clk);
      kv[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, output int n);
      n = 0;
      while (!dn[k] && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Scoreboard consumer: sweep every round key of instance k and compare with the queue.
   task automatic drain_keys(input int k);
      logic [127:0] exp;
      logic [127:0] exp_inv;
      int nr;
      nr = 4 + 2 * k + 6;
      for (int r = 0; r <= nr; r++) begin
         idx[k] = 4'(r);
         #1;
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
         checks++;
         if (rko[k] !== exp || hit[k] !== 1'b1) begin
            errors++;
            $display("FAIL rk%0d inst%0d idx%0d: got %h hit=%b, want %h hit=1",
                     128 + 64 * k, k, r, rko[k], hit[k], exp);
         end
`ifdef AES_INV_KEYS_EN
         exp_inv = (r == 0 || r == nr) ? exp
                 : {inv_col(exp[127:96]), inv_col(exp[95:64]), inv_col(exp[63:32]), inv_col(exp[31:0])};
`else
         exp_inv = 128'h0;
`endif
         checks++;
         if (rki[k] !== exp_inv) begin
            errors++;
            $display("FAIL rk_inv inst%0d idx%0d: got %h, want %h", k, r, rki[k], exp_inv);
         end
         @(negedge clk);
      end
      idx[k] = 4'(nr + 1);
      #1;
      checks++;
      if (hit[k] !== 1'b0 || rko[k] !== 128'h0) begin
         errors++;
         $display("FAIL idx_oob inst%0d: hit=%b rk_out=%h, want hit=0 rk_out=0", k, hit[k], rko[k]);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         kv[k]  = 1'b0;
         idx[k] = 4'd0;
      end
      kw128 = '0; kw192 = '0; kw256 = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({kr[k], bz[k], dn[k], hit[k]} !== 4'b1000) begin
            errors++;
            $display("FAIL reset inst%0d: ready/busy/done/hit=%b%b%b%b, want 1000",
                     k, kr[k], bz[k], dn[k], hit[k]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_expand_128();
      int n;
      load_key(0, 256'h000102030405060708090a0b0c0d0e0f, 1'b1);
      wait_done(0, n);
      checks++;
      if (n !== 40 || dn[0] !== 1'b1) begin
         errors++;
         $display("FAIL latency128: got %0d edges done=%b, want 40", n, dn[0]);
      end
      idx[0] = 4'd1;
      #1;
      checks++;
      if (rko[0] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin
         errors++;
         $display("FAIL vec128_idx1: got %h, want d6aa74fdd2af72fadaa678f1d6ab76fe", rko[0]);
      end
      @(negedge clk);
      checks++;
      if (dn[0] !== 1'b0 || kr[0] !== 1'b1 || bz[0] !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: done=%b ready=%b busy=%b, want 0 1 0", dn[0], kr[0], bz[0]);
      end
      idx[0] = 4'd10;
      #1;
      checks++;
      if (rko[0] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
         errors++;
         $display("FAIL vec128_idx10: got %h, want 13111d7fe3944a17f307a78b4d2b30c5", rko[0]);
      end
      @(negedge clk);
      drain_keys(0);
   endtask

   task automatic test_poll_hit();
      int n;
      int m;
      load_key(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
      idx[0] = 4'd2;
      n = 0;
      while (!hit[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL poll_hit_idx2: got %0d edges, want 8", n);
      end
      wait_done(0, m);
      checks++;
      if (n + m !== 40) begin
         errors++;
         $display("FAIL latency128b: got %0d edges, want 40", n + m);
      end
      idx[0] = 4'd10;
      #1;
      checks++;
      if (rko[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
         errors++;
         $display("FAIL vec128b_idx10: got %h, want d014f9a8c9ee2589e13f0cc8b6630ca6", rko[0]);
      end
      @(negedge clk);
      drain_keys(0);
   endtask

   task automatic test_192_256();
      int n;
      load_key(1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 1'b1);
      wait_done(1, n);
      checks++;
      if (n !== 46) begin
         errors++;
         $display("FAIL latency192: got %0d edges, want 46", n);
      end
      idx[1] = 4'd12;
      #1;
      checks++;
      if (rko[1] !== 128'he98ba06f448c773c8ecc720401002202) begin
         errors++;
         $display("FAIL vec192_idx12: got %h, want e98ba06f448c773c8ecc720401002202", rko[1]);
      end
      @(negedge clk);
      drain_keys(1);
      load_key(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b1);
      wait_done(2, n);
      checks++;
      if (n !== 52) begin
         errors++;
         $display("FAIL latency256: got %0d edges, want 52", n);
      end
      idx[2] = 4'd14;
      #1;
      checks++;
      if (rko[2] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
         errors++;
         $display("FAIL vec256_idx14: got %h, want fe4890d1e6188d0b046df344706c631e", rko[2]);
      end
      @(negedge clk);
      drain_keys(2);
   endtask

   task automatic test_busy_ignore();
      int n;
      logic [255:0] ka;
      logic [255:0] kb;
      ka = {128'h0, $urandom, $urandom, $urandom, $urandom};
      kb = {128'h0, $urandom, $urandom, $urandom, $urandom};
      load_key(0, ka, 1'b1);
      repeat (20) @(negedge clk);
      checks++;
      if (kr[0] !== 1'b0 || bz[0] !== 1'b1) begin
         errors++;
         $display("FAIL busy_mid: ready=%b busy=%b, want 0 1", kr[0], bz[0]);
      end
      load_key(0, kb, 1'b0);
      wait_done(0, n);
      checks++;
      if (n !== 19) begin
         errors++;
         $display("FAIL busy_ignore_latency: got %0d remaining edges, want 19", n);
      end
      @(negedge clk);
      drain_keys(0);
   endtask

   task automatic test_rst_mid();
      int n;
      load_key(0, {128'h0, $urandom, $urandom, $urandom, $urandom}, 1'b0);
      repeat (19) @(negedge clk);
      idx[0] = 4'd0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({kr[0], bz[0], dn[0], hit[0]} !== 4'b1000) begin
         errors++;
         $display("FAIL rst_mid: ready/busy/done/hit=%b%b%b%b, want 1000", kr[0], bz[0], dn[0], hit[0]);
      end
      load_key(0, {128'h0, $urandom, $urandom, $urandom, $urandom}, 1'b1);
      wait_done(0, n);
      checks++;
      if (n !== 40) begin
         errors++;
         $display("FAIL rst_then_latency: got %0d edges, want 40", n);
      end
      @(negedge clk);
      drain_keys(0);
   endtask

   task automatic test_back_to_back();
      int n;
      logic [255:0] kb;
      kb = {128'h0, $urandom, $urandom, $urandom, $urandom};
      load_key(0, {128'h0, $urandom, $urandom, $urandom, $urandom}, 1'b0);
      wait_done(0, n);
      // Reload while done is still high (state DONE)
      load_key(0, kb, 1'b1);
      idx[0] = 4'd1;
      #1;
      checks++;
      if (hit[0] !== 1'b0) begin
         errors++;
         $display("FAIL reload_hit_drop: idx1 hit=%b, want 0", hit[0]);
      end
      idx[0] = 4'd0;
      #1;
      checks++;
      if (hit[0] !== 1'b1 || rko[0] !== kb[127:0]) begin
         errors++;
         $display("FAIL reload_idx0: hit=%b rk=%h, want hit=1 rk=%h", hit[0], rko[0], kb[127:0]);
      end
      wait_done(0, n);
      checks++;
      if (n !== 40) begin
         errors++;
         $display("FAIL reload_latency: got %0d edges, want 40", n);
      end
      @(negedge clk);
      drain_keys(0);
   endtask

   initial begin
      test_reset();
      test_expand_128();
      test_poll_hit();
      test_192_256();
      test_busy_ignore();
      test_rst_mid();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: %0d entries, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
